exception_pipe: RTL and testbench

EXCEPTION_PIPE -- requirements
Module: exception_pipe

---
 rtl/exception_pipe.sv | 188 ++++++++++++++++++
 tb/tb_exception_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/exception_pipe.sv
// exception_pipe: one-stage FP exception classifier with
// valid/ready handshake, sticky class flags and event counter.
module exception_pipe #(
   parameter  int EXP_W  = 4,
   parameter  int MAN_W  = 3,
   parameter  int CNT_W  = 8,
   localparam int DATA_W = 1 + EXP_W + MAN_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [1:0]        FP_OPERATION,
   input  logic [DATA_W-1:0] OP_A,
   input  logic [DATA_W-1:0] OP_B,
   input  logic [3:0]        EXCE_MASK,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OP_IS_EXCEPTION,
   output logic [2:0]        FP_EXCE,
   output logic [3:0]        STICKY_FLAGS,
   input  logic              STICKY_CLR,
   output logic [CNT_W-1:0]  EXCE_COUNT
);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fp_op_e;

   typedef enum logic [2:0] {
      EXC_NONE = 3'b000,
      EXC_QNAN = 3'b001,
      EXC_SNAN = 3'b010,
      EXC_INV  = 3'b011,
      EXC_ZDIV = 3'b100
   } exc_e;

   // Class vector bit positions match EXCE_MASK / STICKY_FLAGS.
   localparam int B_QNAN = 0;
   localparam int B_SNAN = 1;
   localparam int B_INV  = 2;
   localparam int B_ZDIV = 3;

   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   logic             sgn_a, sgn_b;
   logic             nan_a, nan_b;
   logic             snan_a, snan_b;
   logic             inf_a, inf_b;
   logic             zero_a, zero_b;
   logic             invalid;
   logic             div_zero;
   fp_op_e           op;

   exc_e             code;
   logic [3:0]       cls_vec;
   logic             unmasked;
   logic             accept;

   logic             out_valid_q, out_valid_d;
   exc_e             fp_exce_q, fp_exce_d;
   logic             is_exc_q, is_exc_d;
   logic [3:0]       sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sgn_a = OP_A[DATA_W-1];
   assign sgn_b = OP_B[DATA_W-1];
   assign exp_a = OP_A[DATA_W-2 -: EXP_W];
   assign exp_b = OP_B[DATA_W-2 -: EXP_W];
   assign man_a = OP_A[MAN_W-1:0];
   assign man_b = OP_B[MAN_W-1:0];
   assign op    = fp_op_e'(FP_OPERATION);

   // Operand field classification.
   always_comb begin
      nan_a  = (&exp_a) && (|man_a);
      nan_b  = (&exp_b) && (|man_b);
      snan_a = nan_a && !man_a[MAN_W-1];
      snan_b = nan_b && !man_b[MAN_W-1];
      inf_a  = (&exp_a) && !(|man_a);
      inf_b  = (&exp_b) && !(|man_b);
      zero_a = !(|exp_a) && !(|man_a);
      zero_b = !(|exp_b) && !(|man_b);
   end

   // Per-operation invalid and divide-by-zero detection.
   always_comb begin
      invalid  = 1'b0;
      div_zero = 1'b0;
      unique case (op)
         OP_ADD: invalid = inf_a && inf_b && (sgn_a != sgn_b);
         OP_SUB: invalid = inf_a && inf_b && (sgn_a == sgn_b);
         OP_MUL: invalid = (zero_a && inf_b) || (inf_a && zero_b);
         OP_DIV: begin
            invalid  = (zero_a && zero_b) || (inf_a && inf_b);
            div_zero = zero_b && !zero_a && !inf_a && !nan_a;
         end
      endcase
   end

   // Prioritised exception code: NaN, then invalid, then div-by-zero.
   always_comb begin
      code    = EXC_NONE;
      cls_vec = 4'b0000;
      unique case (1'b1)
         (nan_a || nan_b): begin
            if (snan_a || snan_b) begin
               code            = EXC_SNAN;
               cls_vec[B_SNAN] = 1'b1;
            end else begin
               code            = EXC_QNAN;
               cls_vec[B_QNAN] = 1'b1;
            end
         end
         (!(nan_a || nan_b) && invalid): begin
            code           = EXC_INV;
            cls_vec[B_INV] = 1'b1;
         end
         (!(nan_a || nan_b) && !invalid && div_zero): begin
            code            = EXC_ZDIV;
            cls_vec[B_ZDIV] = 1'b1;
         end
         default: begin
            code    = EXC_NONE;
            cls_vec = 4'b0000;
         end
      endcase
      unmasked = |(cls_vec & ~EXCE_MASK);
   end

   assign IN_READY = !out_valid_q || OUT_READY;
   assign accept   = IN_VALID && IN_READY;

   // Next-state for result register, flags and counter.
   always_comb begin
      out_valid_d = out_valid_q;
      fp_exce_d   = fp_exce_q;
      is_exc_d    = is_exc_q;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;
      if (accept) begin
         out_valid_d = 1'b1;
         fp_exce_d   = code;
         is_exc_d    = unmasked;
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
         fp_exce_d   = EXC_NONE;
         is_exc_d    = 1'b0;
      end
      if (STICKY_CLR) begin
         sticky_d = 4'b0000;
         cnt_d    = '0;
      end
      if (accept) begin
         sticky_d = sticky_d | cls_vec;
         if (unmasked && !(&cnt_d)) begin
            cnt_d = cnt_d + 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         fp_exce_q   <= EXC_NONE;
         is_exc_q    <= 1'b0;
         sticky_q    <= 4'b0000;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         fp_exce_q   <= fp_exce_d;
         is_exc_q    <= is_exc_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign OUT_VALID       = out_valid_q;
   assign FP_EXCE         = fp_exce_q;
   assign OP_IS_EXCEPTION = is_exc_q;
   assign STICKY_FLAGS    = sticky_q;
   assign EXCE_COUNT      = cnt_q;

endmodule

// File: tb/tb_exception_pipe.sv
// tb_exception_pipe: directed steps against a scoreboard for two
// instances (default counter width and a 2-bit counter).
module tb_exception_pipe;

   logic       CLK = 1'b0;
   logic       RST;
   logic       IN_VALID;
   logic [1:0] FP_OPERATION;
   logic [7:0] OP_A, OP_B;
   logic [3:0] EXCE_MASK;
   logic       OUT_READY;
   logic       STICKY_CLR;

   logic       rdy0, rdy1, ov0, ov1, ie0, ie1;
   logic [2:0] ex0, ex1;
   logic [3:0] sf0, sf1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   exception_pipe u_dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy0),
      .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
      .EXCE_MASK(EXCE_MASK), .OUT_VALID(ov0), .OUT_READY(OUT_READY),
      .OP_IS_EXCEPTION(ie0), .FP_EXCE(ex0), .STICKY_FLAGS(sf0),
      .STICKY_CLR(STICKY_CLR), .EXCE_COUNT(cnt0)
   );

   exception_pipe #(.CNT_W(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(rdy1),
      .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
      .EXCE_MASK(EXCE_MASK), .OUT_VALID(ov1), .OUT_READY(OUT_READY),
      .OP_IS_EXCEPTION(ie1), .FP_EXCE(ex1), .STICKY_FLAGS(sf1),
      .STICKY_CLR(STICKY_CLR), .EXCE_COUNT(cnt1)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0] code;
      logic       exc;
   } res_t;

   res_t       sb[$];
   logic [3:0] m_sticky;
   int         m_cnt8;
   int         m_cnt2;
   int         checks;
   int         failures;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] ref_code(input logic [1:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
      logic an, bn, as_, bs_, ai, bi, az, bz;
      an  = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
      bn  = (b[6:3] == 4'hF) && (b[2:0] != 3'd0);
      as_ = an && (a[2] == 1'b0);
      bs_ = bn && (b[2] == 1'b0);
      ai  = (a[6:0] == 7'h78);
      bi  = (b[6:0] == 7'h78);
      az  = (a[6:0] == 7'h00);
      bz  = (b[6:0] == 7'h00);
      if (an || bn) return (as_ || bs_) ? 3'd2 : 3'd1;
      if (op == 2'd0 && ai && bi && a[7] != b[7]) return 3'd3;
      if (op == 2'd1 && ai && bi && a[7] == b[7]) return 3'd3;
      if (op == 2'd2 && ((az && bi) || (ai && bz))) return 3'd3;
      if (op == 2'd3 && ((az && bz) || (ai && bi))) return 3'd3;
      if (op == 2'd3 && bz && !az && !ai) return 3'd4;
      return 3'd0;
   endfunction

   task automatic step(input logic rst, input logic v,
                       input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] m,
                       input logic ordy, input logic clr);
      logic       rdy_m, acc;
      logic [2:0] c;
      logic [3:0] cv;
      logic       e;
      @(negedge CLK);
      RST = rst; IN_VALID = v; FP_OPERATION = op;
      OP_A = a; OP_B = b; EXCE_MASK = m;
      OUT_READY = ordy; STICKY_CLR = clr;
      #1;
      rdy_m = (sb.size() == 0) || ordy;
      chk("in_ready", {31'd0, rdy0}, {31'd0, rdy_m});
      chk("in_ready_w2", {31'd0, rdy1}, {31'd0, rdy_m});
      acc = v && rdy_m;
      c   = ref_code(op, a, b);
      cv  = (c == 3'd0) ? 4'b0000 : (4'b0001 << (c - 3'd1));
      e   = |(cv & ~m);
      @(posedge CLK);
      if (rst) begin
         sb.delete();
         m_sticky = 4'b0000;
         m_cnt8   = 0;
         m_cnt2   = 0;
      end else begin
         if (sb.size() > 0 && ordy) sb.delete(0);
         if (acc) sb.push_back('{code: c, exc: e});
         if (clr) begin
            m_sticky = 4'b0000;
            m_cnt8   = 0;
            m_cnt2   = 0;
         end
         if (acc) begin
            m_sticky = m_sticky | cv;
            if (e && m_cnt8 < 255) m_cnt8++;
            if (e && m_cnt2 < 3) m_cnt2++;
         end
      end
      #1;
      chk("out_valid", {31'd0, ov0}, {31'd0, sb.size() > 0});
      chk("out_valid_w2", {31'd0, ov1}, {31'd0, sb.size() > 0});
      if (sb.size() > 0) begin
         chk("fp_exce", {29'd0, ex0}, {29'd0, sb[0].code});
         chk("is_exc", {31'd0, ie0}, {31'd0, sb[0].exc});
      end else begin
         chk("fp_exce_idle", {29'd0, ex0}, 32'd0);
         chk("is_exc_idle", {31'd0, ie0}, 32'd0);
      end
      chk("fp_exce_w2", {29'd0, ex1}, {29'd0, ex0});
      chk("sticky", {28'd0, sf0}, {28'd0, m_sticky});
      chk("sticky_w2", {28'd0, sf1}, {28'd0, m_sticky});
      chk("count", {24'd0, cnt0}, m_cnt8);
      chk("count_w2", {30'd0, cnt1}, m_cnt2);
   endtask

   initial begin
      checks = 0; failures = 0;
      m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
      RST = 1'b1; IN_VALID = 1'b0; FP_OPERATION = 2'd0;
      OP_A = 8'h00; OP_B = 8'h00; EXCE_MASK = 4'h0;
      OUT_READY = 1'b1; STICKY_CLR = 1'b0;
      @(posedge CLK);
      // reset state
      step(1, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 0);
      // +inf + -inf -> invalid
      step(0, 1, 2'd0, 8'h78, 8'hF8, 4'h0, 1, 0);
      // NaN and divide cases
      step(0, 1, 2'd2, 8'h7C, 8'h79, 4'h0, 1, 0);
      step(0, 1, 2'd3, 8'h38, 8'h00, 4'h0, 1, 0);
      step(0, 1, 2'd3, 8'h00, 8'h00, 4'h0, 1, 0);
      step(0, 1, 2'd3, 8'h78, 8'h00, 4'h0, 1, 0);
      step(0, 1, 2'd0, 8'h7C, 8'h38, 4'h0, 1, 0);
      step(0, 1, 2'd3, 8'hF8, 8'h78, 4'h0, 1, 0);
      step(0, 1, 2'd2, 8'h80, 8'hF8, 4'h0, 1, 0);
      step(0, 1, 2'd1, 8'h78, 8'hF8, 4'h0, 1, 0);
      step(0, 1, 2'd0, 8'h78, 8'h78, 4'h0, 1, 0);
      step(0, 1, 2'd2, 8'h38, 8'h38, 4'h0, 1, 0);
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 0);
      // backpressure: held result, then drain
      step(0, 1, 2'd3, 8'h38, 8'h00, 4'h0, 0, 0);
      step(0, 1, 2'd0, 8'h7C, 8'h00, 4'h0, 0, 0);
      step(0, 1, 2'd2, 8'h79, 8'h00, 4'h0, 0, 0);
      step(0, 1, 2'd1, 8'h78, 8'h78, 4'h0, 0, 0);
      step(0, 1, 2'd2, 8'h79, 8'h00, 4'h0, 1, 0);
      step(0, 1, 2'd0, 8'h38, 8'h38, 4'h0, 1, 0);
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 0);
      // masked invalid, after a clear
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 1);
      step(0, 1, 2'd1, 8'h78, 8'h78, 4'h4, 1, 0);
      step(0, 1, 2'd3, 8'h38, 8'h80, 4'h8, 1, 0);
      step(0, 1, 2'd2, 8'h7C, 8'h38, 4'h1, 1, 0);
      step(0, 1, 2'd0, 8'h79, 8'h38, 4'h1, 1, 0);
      // saturate narrow counter
      step(0, 1, 2'd0, 8'h78, 8'hF8, 4'h0, 1, 0);
      step(0, 1, 2'd3, 8'h38, 8'h00, 4'h0, 1, 0);
      step(0, 1, 2'd2, 8'h00, 8'h78, 4'h0, 1, 0);
      step(0, 1, 2'd0, 8'h7C, 8'h7C, 4'h0, 1, 0);
      step(0, 1, 2'd1, 8'hF8, 8'hF8, 4'h0, 1, 0);
      // clear with same-cycle exception
      step(0, 1, 2'd3, 8'h38, 8'h00, 4'h0, 1, 1);
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 1);
      // reset while holding a result under backpressure
      step(0, 1, 2'd0, 8'h78, 8'hF8, 4'h0, 0, 0);
      step(0, 1, 2'd3, 8'h38, 8'h00, 4'h0, 0, 0);
      step(1, 1, 2'd3, 8'h38, 8'h00, 4'h0, 0, 1);
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 0, 0);
      step(0, 1, 2'd2, 8'h7C, 8'h38, 4'h0, 1, 0);
      step(0, 0, 2'd0, 8'h00, 8'h00, 4'h0, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
